// File: rtl/polar_llr_frame_buffer_if.sv
// LLR input stream, decoder read port and status pulses of the polar LLR frame buffer.
interface polar_llr_frame_buffer_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int IN_WIDTH    = 12,
   parameter int CODE_LENGTH = 1024
);
   localparam int COUNTER_WIDTH = $clog2(CODE_LENGTH);

   logic                         in_valid;
   logic                         in_ready;
   logic signed [IN_WIDTH-1:0]   in_data;
   logic                         in_last;
   logic                         frame_valid;
   logic [COUNTER_WIDTH-1:0]     rd_addr;
   logic signed [DATA_WIDTH-1:0] rd_data;
   logic                         frame_done;
   logic                         err_len;
   logic                         frame_dropped;

   modport master (
      output in_valid, in_data, in_last, rd_addr, frame_done,
      input  in_ready, frame_valid, rd_data, err_len, frame_dropped
   );

   modport slave (
      input  in_valid, in_data, in_last, rd_addr, frame_done,
      output in_ready, frame_valid, rd_data, err_len, frame_dropped
   );
endinterface

// File: rtl/polar_llr_frame_buffer.sv
// Ping-pong LLR frame buffer: saturates channel LLRs and assembles CODE_LENGTH-sample
// frames in one bank while the SC decoder reads the other bank by address.
module polar_llr_frame_buffer #(
   parameter int DATA_WIDTH  = 8,
   parameter int IN_WIDTH    = 12,
   parameter int CODE_LENGTH = 1024,
   parameter bit BIT_REVERSE = 1'b0
) (
   input  logic                    clk,
   input  logic                    reset,
   polar_llr_frame_buffer_if.slave bus
);
   localparam int COUNTER_WIDTH = $clog2(CODE_LENGTH);
   localparam int DEPTH         = 32'sd2 * CODE_LENGTH;
   localparam logic [COUNTER_WIDTH-1:0] LAST_CNT = COUNTER_WIDTH'(CODE_LENGTH - 32'sd1);
   localparam logic signed [IN_WIDTH-1:0] SAT_MAX =
      IN_WIDTH'((32'sd1 <<< (DATA_WIDTH - 32'sd1)) - 32'sd1);
   localparam logic signed [IN_WIDTH-1:0] SAT_MIN = -SAT_MAX;

   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2
   } bank_state_t;

   // Symmetric clamp: the most negative DATA_WIDTH code is never produced.
   function automatic logic [DATA_WIDTH-1:0] saturate(input logic signed [IN_WIDTH-1:0] value);
      logic signed [IN_WIDTH-1:0] clamped;
      if (value > SAT_MAX) begin
         clamped = SAT_MAX;
      end else if (value < SAT_MIN) begin
         clamped = SAT_MIN;
      end else begin
         clamped = value;
      end
      return DATA_WIDTH'(clamped);
   endfunction

   function automatic logic [COUNTER_WIDTH-1:0] bitrev(input logic [COUNTER_WIDTH-1:0] addr);
      logic [COUNTER_WIDTH-1:0] rev;
      for (int k = 32'sd0; k < COUNTER_WIDTH; k++) begin
         rev[k] = addr[COUNTER_WIDTH - 32'sd1 - k];
      end
      return rev;
   endfunction

   bank_state_t [1:0]        state_r;
   bank_state_t [1:0]        state_s;
   logic                     wr_bank_r;
   logic                     wr_bank_s;
   logic                     rd_bank_r;
   logic                     rd_bank_s;
   logic [COUNTER_WIDTH-1:0] wr_cnt_r;
   logic [COUNTER_WIDTH-1:0] wr_cnt_s;
   logic [COUNTER_WIDTH-1:0] wr_addr_s;
   logic                     ready_en_r;
   logic                     frame_valid_r;
   logic                     frame_valid_s;
   logic                     err_len_r;
   logic                     err_len_s;
   logic                     frame_dropped_r;
   logic [DATA_WIDTH-1:0]    rd_data_r;
   logic [DATA_WIDTH-1:0]    mem [DEPTH];
   logic                     in_ready_s;
   logic                     accept_s;
   logic                     done_s;
   logic                     at_end_s;
   logic                     commit_s;
   logic                     drop_s;

   // ready_en_r holds in_ready low for the reset cycle itself.
   assign in_ready_s = ready_en_r && (state_r[wr_bank_r] != BANK_FULL);
   assign accept_s   = bus.in_valid && in_ready_s;
   assign done_s     = bus.frame_done && frame_valid_r;
   assign at_end_s   = (wr_cnt_r == LAST_CNT);
   assign commit_s   = accept_s && at_end_s;
   assign drop_s     = accept_s && !at_end_s && bus.in_last;
   assign wr_addr_s  = BIT_REVERSE ? bitrev(wr_cnt_r) : wr_cnt_r;

   // Next bank states, counters and status pulses.
   always_comb begin
      state_s       = state_r;
      wr_cnt_s      = wr_cnt_r;
      wr_bank_s     = wr_bank_r;
      rd_bank_s     = rd_bank_r;
      frame_valid_s = 1'b0;
      err_len_s     = 1'b0;
      if (commit_s) begin
         state_s[wr_bank_r] = BANK_FULL;
         wr_cnt_s           = {COUNTER_WIDTH{1'b0}};
         wr_bank_s          = ~wr_bank_r;
      end else if (drop_s) begin
         state_s[wr_bank_r] = BANK_EMPTY;
         wr_cnt_s           = {COUNTER_WIDTH{1'b0}};
      end else if (accept_s) begin
         state_s[wr_bank_r] = BANK_FILLING;
         wr_cnt_s           = wr_cnt_r + 1'b1;
      end else begin
         wr_cnt_s = wr_cnt_r;
      end
      // Commit and release always hit different banks, so both apply.
      if (done_s) begin
         state_s[rd_bank_r] = BANK_EMPTY;
         rd_bank_s          = ~rd_bank_r;
         frame_valid_s      = (state_r[~rd_bank_r] == BANK_FULL);
      end else begin
         frame_valid_s = (state_r[rd_bank_r] == BANK_FULL);
      end
      err_len_s = (commit_s && !bus.in_last) || drop_s;
   end

   // Bank bookkeeping and registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r[0]      <= BANK_EMPTY;
         state_r[1]      <= BANK_EMPTY;
         wr_bank_r       <= 1'b0;
         rd_bank_r       <= 1'b0;
         wr_cnt_r        <= {COUNTER_WIDTH{1'b0}};
         ready_en_r      <= 1'b0;
         frame_valid_r   <= 1'b0;
         err_len_r       <= 1'b0;
         frame_dropped_r <= 1'b0;
      end else begin
         state_r         <= state_s;
         wr_bank_r       <= wr_bank_s;
         rd_bank_r       <= rd_bank_s;
         wr_cnt_r        <= wr_cnt_s;
         ready_en_r      <= 1'b1;
         frame_valid_r   <= frame_valid_s;
         err_len_r       <= err_len_s;
         frame_dropped_r <= drop_s;
      end
   end

   // Frame storage; contents need no reset since bank state gates every use.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         mem[{wr_bank_r, wr_addr_s}] <= saturate(bus.in_data);
      end
   end

   // Synchronous read port, frozen while no frame is presented.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_r <= {DATA_WIDTH{1'b0}};
      end else if (frame_valid_r) begin
         rd_data_r <= mem[{rd_bank_r, bus.rd_addr}];
      end
   end

   assign bus.in_ready      = in_ready_s;
   assign bus.frame_valid   = frame_valid_r;
   assign bus.rd_data       = rd_data_r;
   assign bus.err_len       = err_len_r;
   assign bus.frame_dropped = frame_dropped_r;
endmodule

// File: tb/tb_polar_llr_frame_buffer.sv
// Directed/random bench for polar_llr_frame_buffer: a 1024-sample natural-order
// instance and an 8-sample bit-reversed instance checked against frame queues.
module tb_polar_llr_frame_buffer;
   localparam int DW   = 8;
   localparam int IW   = 12;
   localparam int CL_A = 1024;
   localparam int CL_B = 8;

   logic clk;
   logic reset_a;
   logic reset_b;
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model: committed frames in logical sample order, oldest first.
   int   frm_a[$];
   int   part_a[$];
   int   frm_b[$];
   int   part_b[$];
   int   sat_v[5];

   polar_llr_frame_buffer_if #(.DATA_WIDTH(DW), .IN_WIDTH(IW), .CODE_LENGTH(CL_A)) ifa ();
   polar_llr_frame_buffer_if #(.DATA_WIDTH(DW), .IN_WIDTH(IW), .CODE_LENGTH(CL_B)) ifb ();

   polar_llr_frame_buffer #(.DATA_WIDTH(DW), .IN_WIDTH(IW), .CODE_LENGTH(CL_A), .BIT_REVERSE(1'b0))
      dut_a (.clk(clk), .reset(reset_a), .bus(ifa.slave));
   polar_llr_frame_buffer #(.DATA_WIDTH(DW), .IN_WIDTH(IW), .CODE_LENGTH(CL_B), .BIT_REVERSE(1'b1))
      dut_b (.clk(clk), .reset(reset_b), .bus(ifb.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: time %0t reached without finishing, required earlier end", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic int clamp(input int v);
      int lim;
      lim = (1 << (DW - 1)) - 1;
      if (v > lim) return lim;
      if (v < -lim) return -lim;
      return v;
   endfunction

   function automatic int rev(input int a, input int bits);
      int r;
      r = 0;
      for (int k = 0; k < bits; k++) r = (r << 1) | ((a >> k) & 1);
      return r;
   endfunction

   function automatic int rnd_llr();
      if ($urandom_range(1) == 0) return int'($urandom_range(320)) - 160;
      return int'($urandom_range(4095)) - 2048;
   endfunction

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Offer one sample (called at a negedge); returns at the negedge after acceptance.
   task automatic push(input bit sel, input int v, input bit last);
      int g;
      bit exp_err;
      bit exp_drop;
      g = 0;
      if (sel) begin
         ifb.in_valid = 1'b1; ifb.in_data = IW'(v); ifb.in_last = last;
      end else begin
         ifa.in_valid = 1'b1; ifa.in_data = IW'(v); ifa.in_last = last;
      end
      while (((sel ? ifb.in_ready : ifa.in_ready) !== 1'b1) && g < 64) begin
         @(negedge clk);
         g++;
      end
      if ((sel ? ifb.in_ready : ifa.in_ready) !== 1'b1) begin
         check("in_ready_wait", sel ? ifb.in_ready : ifa.in_ready, 1);
         ifa.in_valid = 1'b0;
         ifb.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      ifa.in_valid = 1'b0;
      ifb.in_valid = 1'b0;
      exp_err  = 1'b0;
      exp_drop = 1'b0;
      if (sel) begin
         part_b.push_back(clamp(v));
         if (part_b.size() == CL_B) begin
            foreach (part_b[k]) frm_b.push_back(part_b[k]);
            part_b.delete();
            exp_err = !last;
         end else if (last) begin
            part_b.delete();
            exp_err  = 1'b1;
            exp_drop = 1'b1;
         end
         check("err_len_b", ifb.err_len, exp_err);
         check("frame_dropped_b", ifb.frame_dropped, exp_drop);
      end else begin
         part_a.push_back(clamp(v));
         if (part_a.size() == CL_A) begin
            foreach (part_a[k]) frm_a.push_back(part_a[k]);
            part_a.delete();
            exp_err = !last;
         end else if (last) begin
            part_a.delete();
            exp_err  = 1'b1;
            exp_drop = 1'b1;
         end
         check("err_len_a", ifa.err_len, exp_err);
         check("frame_dropped_a", ifa.frame_dropped, exp_drop);
      end
   endtask

   task automatic rd(input bit sel, input int addr, input string tag);
      if (sel) ifb.rd_addr = 3'(addr);
      else ifa.rd_addr = 10'(addr);
      @(posedge clk);
      @(negedge clk);
      if (sel) check(tag, ifb.rd_data, frm_b[rev(addr, 3)]);
      else check(tag, ifa.rd_data, frm_a[addr]);
   endtask

   task automatic done(input bit sel);
      if (sel) ifb.frame_done = 1'b1;
      else ifa.frame_done = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ifa.frame_done = 1'b0;
      ifb.frame_done = 1'b0;
      if (sel) begin
         if (frm_b.size() >= CL_B) repeat (CL_B) void'(frm_b.pop_front());
      end else begin
         if (frm_a.size() >= CL_A) repeat (CL_A) void'(frm_a.pop_front());
      end
   endtask

   task automatic do_reset(input bit sel);
      if (sel) reset_b = 1'b1;
      else reset_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ifa.in_valid = 1'b0;
      ifb.in_valid = 1'b0;
      if (sel) begin
         check("rst_in_ready_b", ifb.in_ready, 0);
         check("rst_frame_valid_b", ifb.frame_valid, 0);
         frm_b.delete(); part_b.delete();
         reset_b = 1'b0;
      end else begin
         check("rst_in_ready_a", ifa.in_ready, 0);
         check("rst_frame_valid_a", ifa.frame_valid, 0);
         check("rst_rd_data_a", ifa.rd_data, 0);
         check("rst_err_len_a", ifa.err_len, 0);
         check("rst_frame_dropped_a", ifa.frame_dropped, 0);
         frm_a.delete(); part_a.delete();
         reset_a = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      check("post_rst_in_ready", sel ? ifb.in_ready : ifa.in_ready, 1);
      check("post_rst_frame_valid", sel ? ifb.frame_valid : ifa.frame_valid, 0);
   endtask

   initial begin
      reset_a = 1'b1; reset_b = 1'b1;
      ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_last = 1'b0; ifa.rd_addr = '0; ifa.frame_done = 1'b0;
      ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_last = 1'b0; ifb.rd_addr = '0; ifb.frame_done = 1'b0;
      sat_v = '{300, -300, -128, 5, -127};
      @(negedge clk);
      do_reset(1'b0);
      do_reset(1'b1);

      // Ramp frame: frame_valid rises one cycle after the last accept.
      for (int i = 0; i < CL_A; i++) push(1'b0, i - 512, i == CL_A - 1);
      check("fv_at_commit", ifa.frame_valid, 0);
      @(posedge clk);
      @(negedge clk);
      check("fv_after_commit", ifa.frame_valid, 1);
      check("err_len_idle", ifa.err_len, 0);
      rd(1'b0, 0, "rd_addr0");
      rd(1'b0, 384, "rd_addr384");
      rd(1'b0, 500, "rd_addr500");
      rd(1'b0, 1023, "rd_addr1023");
      for (int k = 0; k < 24; k++) rd(1'b0, int'($urandom_range(CL_A - 1)), "rd_ramp_rand");
      done(1'b0);
      check("fv_after_done", ifa.frame_valid, 0);

      // Saturation boundaries at the head of a random frame.
      for (int i = 0; i < CL_A; i++) push(1'b0, (i < 5) ? sat_v[i] : rnd_llr(), i == CL_A - 1);
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 5; i++) rd(1'b0, i, "rd_sat");
      for (int k = 0; k < 8; k++) rd(1'b0, int'($urandom_range(CL_A - 1)), "rd_sat_rand");
      done(1'b0);

      // Back-to-back frames with no release until both banks are full.
      for (int f = 0; f < 2; f++)
         for (int i = 0; i < CL_A; i++) push(1'b0, rnd_llr(), i == CL_A - 1);
      check("in_ready_both_full", ifa.in_ready, 32'(frm_a.size() < 2 * CL_A));
      repeat (3) @(negedge clk);
      check("in_ready_still_low", ifa.in_ready, 0);
      check("fv_both_full", ifa.frame_valid, 32'(frm_a.size() >= CL_A));
      done(1'b0);
      check("in_ready_after_done", ifa.in_ready, 1);
      check("fv_across_switch", ifa.frame_valid, 1);
      for (int k = 0; k < 8; k++) rd(1'b0, int'($urandom_range(CL_A - 1)), "rd_second");
      for (int i = 0; i < CL_A; i++) begin
         push(1'b0, rnd_llr(), i == CL_A - 1);
         if (i % 256 == 0) check("fv_while_filling", ifa.frame_valid, 1);
      end
      done(1'b0);
      check("fv_third_frame", ifa.frame_valid, 1);
      for (int k = 0; k < 8; k++) rd(1'b0, int'($urandom_range(CL_A - 1)), "rd_third");
      done(1'b0);
      check("fv_all_released", ifa.frame_valid, 0);

      // Early in_last on sample 100 drops the frame; next frame starts at address 0.
      do_reset(1'b0);
      for (int i = 0; i < 100; i++) push(1'b0, rnd_llr(), i == 99);
      @(posedge clk);
      @(negedge clk);
      check("err_len_single", ifa.err_len, 0);
      check("dropped_single", ifa.frame_dropped, 0);
      check("fv_after_drop", ifa.frame_valid, 0);
      for (int i = 0; i < CL_A; i++) push(1'b0, rnd_llr(), i == CL_A - 1);
      @(posedge clk);
      @(negedge clk);
      check("fv_after_refill", ifa.frame_valid, 1);
      rd(1'b0, 0, "rd_refill_addr0");
      rd(1'b0, 99, "rd_refill_addr99");
      for (int k = 0; k < 8; k++) rd(1'b0, int'($urandom_range(CL_A - 1)), "rd_refill_rand");
      done(1'b0);

      // Missing in_last on the final sample still commits, with one err_len pulse.
      for (int i = 0; i < CL_A; i++) push(1'b0, rnd_llr(), 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("err_len_once", ifa.err_len, 0);
      check("fv_no_last", ifa.frame_valid, 1);
      for (int k = 0; k < 8; k++) rd(1'b0, int'($urandom_range(CL_A - 1)), "rd_no_last");
      done(1'b0);

      // Bit-reversed 8-sample instance, then reset in the middle of a frame.
      for (int i = 0; i < CL_B; i++) push(1'b1, i, i == CL_B - 1);
      @(posedge clk);
      @(negedge clk);
      check("fv_b", ifb.frame_valid, 1);
      for (int a = 0; a < CL_B; a++) rd(1'b1, a, "rd_bitrev");
      for (int i = 0; i < 5; i++) push(1'b1, rnd_llr(), 1'b0);
      ifb.in_valid = 1'b1; ifb.in_data = 12'sd5; ifb.in_last = 1'b0;
      do_reset(1'b1);
      for (int i = 0; i < CL_B; i++) push(1'b1, rnd_llr(), i == CL_B - 1);
      @(posedge clk);
      @(negedge clk);
      check("fv_b_after_reset", ifb.frame_valid, 1);
      for (int a = 0; a < CL_B; a++) rd(1'b1, a, "rd_bitrev_after_reset");
      done(1'b1);
      check("fv_b_released", ifb.frame_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/polar_llr_frame_buffer.md
Name: polar_llr_frame_buffer

Overview:
Upstream neighbour of the polar SC decoder core. Accepts a stream of channel LLRs through a valid/ready handshake, saturates each one to the decoder's LLR width and assembles CODE_LENGTH samples into a frame. Frames are held in a two-bank ping-pong RAM, so one frame can fill while the decoder reads the other by address. The decoder releases a bank explicitly once it has finished with it.

Parameters:
DATA_WIDTH, 8, decoder LLR width (signed two's complement)
IN_WIDTH, 12, channel LLR width (signed), must be >= DATA_WIDTH
CODE_LENGTH, 1024, samples per frame, power of 2
BIT_REVERSE, 0, 1 = store sample i at bit-reversed address of i; 0 = natural order
(local) COUNTER_WIDTH = $clog2(CODE_LENGTH)

Ports:
clk  in  1  single clock, all logic rising-edge
reset  in  1  synchronous, active-high
in_valid  in  1  input sample valid
in_ready  out  1  buffer can accept a sample this cycle
in_data  in  IN_WIDTH  signed channel LLR
in_last  in  1  marks last sample of a frame
frame_valid  out  1  a complete frame is available to the decoder
rd_addr  in  COUNTER_WIDTH  decoder read address
rd_data  out  DATA_WIDTH  LLR at rd_addr of the current read bank, 1-cycle latency
frame_done  in  1  single-cycle pulse: decoder finished with the current frame
err_len  out  1  single-cycle pulse: frame-length violation
frame_dropped  out  1  single-cycle pulse: frame discarded because of early in_last

Behaviour:
- Reset values: in_ready=0 in the reset cycle, then 1 on the first cycle after reset is released. frame_valid=0, rd_data=0, err_len=0, frame_dropped=0. Both banks EMPTY. wr_bank=0, rd_bank=0, wr_cnt=0.
- Reset asserted mid-frame or mid-read discards all stored data and state. Nothing is committed.
- Per-bank state: EMPTY -> FILLING (first sample accepted) -> FULL (commit) -> EMPTY (frame_done).
- in_ready = (state[wr_bank] == EMPTY or FILLING). It depends only on registered state, never on in_valid.
- Accept when in_valid && in_ready. The sample is written to address wr_cnt (or bitrev(wr_cnt) if BIT_REVERSE=1) in bank wr_bank, and wr_cnt increments.
- Saturation: clamp to the symmetric range [-(2^(DATA_WIDTH-1)-1), +(2^(DATA_WIDTH-1)-1)]. Values in range pass unchanged. The most negative DATA_WIDTH code is never stored.
- Commit, on an accepted sample with wr_cnt == CODE_LENGTH-1:
  - bank goes FULL, wr_cnt -> 0, wr_bank toggles.
  - If in_last is 0 on this sample: commit anyway and pulse err_len the next cycle.
- Early in_last (accepted with wr_cnt < CODE_LENGTH-1):
  - bank returns to EMPTY, wr_cnt -> 0, wr_bank unchanged.
  - Pulse err_len and frame_dropped the next cycle.
- frame_valid = (state[rd_bank] == FULL), registered. It rises the cycle after the commit edge, so the last sample accepted at edge t gives frame_valid=1 after edge t+1.
- frame_done while frame_valid=1: rd_bank goes EMPTY, rd_bank toggles, and frame_valid is re-evaluated from the other bank on the next cycle.
- frame_done while frame_valid=0 is ignored.
- Commit and frame_done in the same cycle are both applied. With back-to-back frames, frame_valid may therefore stay high continuously across the bank switch.
- Both banks FULL: in_ready=0 until frame_done.
- rd_data is registered: rd_addr sampled at edge t gives data after edge t. Reads are always from rd_bank.
- rd_data holds its last value when frame_valid=0; its content is don't-care in that case.
- Storage: 2*CODE_LENGTH x DATA_WIDTH simple dual-port RAM with a synchronous read port.

Test Plan:
1. Reset, then stream 1024 samples in_data=i-512 (IN_WIDTH=12, DATA_WIDTH=8), in_last on the 1024th -> frame_valid rises 1 cycle after the last accept; reading addresses 0..1023 gives clamp(i-512) (addr 0 -> -127, addr 384 -> -127, addr 500 -> -12, addr 1023 -> 127); err_len never pulses.
2. Saturation: in_data 300, -300, -128, 5, -127 -> stored 127, -127, -127, 5, -127.
3. Back-to-back: three frames with no gaps and frame_done never asserted -> in_ready drops after the second commit. Pulse frame_done -> in_ready=1 the next cycle, the third frame fills bank 0, and frame_valid stays 1 while rd_bank switches to bank 1.
4. Early in_last at sample 100 -> err_len=1 and frame_dropped=1 for one cycle, frame_valid stays 0, and the next full frame lands at address 0 of bank 0.
5. Missing in_last on sample 1023 -> frame commits, frame_valid=1, err_len pulses once, frame_dropped=0.
6. BIT_REVERSE=1, CODE_LENGTH=8, samples 0..7 -> rd_addr 1 gives 4 and rd_addr 6 gives 3. Reset asserted at sample 5 of a second frame -> frame_valid=0, in_ready=1 after reset is released, and the next frame is stored from address 0.
